// File: rtl/gate_sweep_checker_if.sv
// Bundles the signals between the sweep checker, its controller and the gate under test.
// The checker side (master) drives the gate inputs and the run status.
// The environment side (slave) provides the start request and the gate output.
interface gate_sweep_checker_if;
   logic       start;
   logic       a_o;
   logic       b_o;
   logic       c_i;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;

   modport master (
      input  start,
      input  c_i,
      output a_o,
      output b_o,
      output busy,
      output done,
      output pass,
      output err_count
   );

   modport slave (
      output start,
      output c_i,
      input  a_o,
      input  b_o,
      input  busy,
      input  done,
      input  pass,
      input  err_count
   );
endinterface

// File: rtl/gate_sweep_checker.sv
// Drives a two-input gate through its full truth table for PASSES sweeps.
// Each vector is held SETTLE+1 cycles, and the gate output is sampled on the last of them.
// The sample is compared against AND (Impl=0) or OR (Impl=1).
// The checker reports a saturating mismatch count and a pass flag.
module gate_sweep_checker #(
   parameter bit Impl   = 1'b0, // expected gate function: 0 = AND, 1 = OR
   parameter int PASSES = 4,    // full truth-table sweeps per run, 1..255
   parameter int SETTLE = 1     // extra hold cycles per vector, 0..15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gate_sweep_checker_if.master bus
);

   localparam logic [3:0] HOLD_MAX  = 4'(SETTLE);
   localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] vec_q,   vec_d;
   logic [3:0] hold_q,  hold_d;
   logic [7:0] pcnt_q,  pcnt_d;
   logic       a_q,     a_d;
   logic       b_q,     b_d;
   logic       busy_q,  busy_d;
   logic       done_q,  done_d;
   logic       pass_q,  pass_d;
   logic [7:0] err_q,   err_d;

   logic       expected;
   logic       mismatch;
   logic [7:0] err_inc;

   // The gate output is combinational from the registered drives, so compare against those.
   assign expected = Impl ? (a_q | b_q) : (a_q & b_q);
   assign mismatch = (bus.c_i != expected);
   assign err_inc  = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);

   // State and output registers; an asynchronous reset discards any partial run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= 2'd0;
         hold_q  <= 4'd0;
         pcnt_q  <= 8'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         pcnt_q  <= pcnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: sweep the vectors, count mismatches, and finish after the last vector of the last pass.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      hold_d  = hold_q;
      pcnt_d  = pcnt_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = DRIVE;
               vec_d   = 2'd0;
               hold_d  = 4'd0;
               pcnt_d  = 8'd0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               err_d   = 8'd0;
            end
         end

         DRIVE: begin
            if (hold_q == HOLD_MAX) begin
               hold_d = 4'd0;
               if (mismatch) begin
                  err_d = err_inc;
               end
               if ((vec_q == 2'd3) && (pcnt_q == LAST_PASS)) begin
                  // The final comparison is already folded into err_d, so pass reflects the whole run.
                  state_d = DONE;
                  vec_d   = 2'd0;
                  pcnt_d  = 8'd0;
                  a_d     = 1'b0;
                  b_d     = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 8'd0);
               end else begin
                  vec_d = vec_q + 2'd1;
                  if (vec_q == 2'd3) begin
                     pcnt_d = pcnt_q + 8'd1;
                  end
                  a_d = vec_d[1];
                  b_d = vec_d[0];
               end
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.a_o       = a_q;
   assign bus.b_o       = b_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;

endmodule
